// File: rtl/dma_region_sched.sv
// dma_region_sched: credit-capped round-robin arbiter from N_REGIONS MMU request streams onto one DMA request port plus a mux ordering port; `define DMA_SCHED_WEIGHT_EN adds per-region burst weights.
// Latency: accept in cycle t, m_req_valid/m_mux_valid from t+1; at best one grant every 2 cycles.
// Backpressure: no accept until both the DMA and mux handshakes of the current grant have completed; regions at MAX_OUT are skipped.
module dma_region_sched #(
   parameter int N_REGIONS = 4,
   parameter int LEN_BITS  = 28,
   parameter int REQ_BITS  = 96,
   parameter int MAX_OUT   = 8,
   localparam int ID_BITS  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
   localparam int CNT_BITS = $clog2(MAX_OUT + 1)
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [N_REGIONS-1:0]          s_req_valid,
   output logic [N_REGIONS-1:0]          s_req_ready,
   input  logic [N_REGIONS*REQ_BITS-1:0] s_req_data,
   input  logic [N_REGIONS*LEN_BITS-1:0] s_req_len,
   output logic                          m_req_valid,
   input  logic                          m_req_ready,
   output logic [REQ_BITS-1:0]           m_req_data,
   output logic [LEN_BITS-1:0]           m_req_len,
   output logic [ID_BITS-1:0]            m_req_id,
   output logic                          m_mux_valid,
   input  logic                          m_mux_ready,
   output logic [ID_BITS-1:0]            m_mux_id,
   output logic [LEN_BITS-1:0]           m_mux_len,
   input  logic [N_REGIONS-1:0]          xfer_done,
   output logic [N_REGIONS*CNT_BITS-1:0] out_cnt,
`ifdef DMA_SCHED_WEIGHT_EN
   input  logic [N_REGIONS*4-1:0]        weight,
`endif
   output logic                          credit_err
);

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [ID_BITS-1:0]  id;
      logic [LEN_BITS-1:0] len;
      logic [REQ_BITS-1:0] data;
   } entry_t;

   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_OUT);
   localparam logic [ID_BITS-1:0]  LAST_ID = ID_BITS'(N_REGIONS - 1);

   state_t               state_q, state_nxt;
   entry_t               entry_q, entry_sel;
   logic [CNT_BITS-1:0]  cnt_q [N_REGIONS];
   logic [N_REGIONS-1:0] eligible;
   logic                 grant_vld;
   logic [ID_BITS-1:0]   grant, grant_succ;
   logic [ID_BITS-1:0]   rr_ptr_q, nxt_ptr_q, nxt_ptr;
   logic                 accept, req_hs, mux_hs, issue_done;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         eligible[i] = s_req_valid[i] && (cnt_q[i] < CNT_MAX);
      end
   end

   // First eligible region at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 0; k < N_REGIONS; k++) begin
         idx = (int'(rr_ptr_q) + k) % N_REGIONS;
         if (!grant_vld && eligible[ID_BITS'(idx)]) begin
            grant_vld = 1'b1;
            grant     = ID_BITS'(idx);
         end
      end
   end

   always_comb begin
      entry_sel    = '0;
      entry_sel.id = grant;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (grant == ID_BITS'(i)) begin
            entry_sel.len  = s_req_len[i*LEN_BITS +: LEN_BITS];
            entry_sel.data = s_req_data[i*REQ_BITS +: REQ_BITS];
         end
      end
   end

   assign grant_succ = (grant == LAST_ID) ? '0 : grant + ID_BITS'(1);

`ifdef DMA_SCHED_WEIGHT_EN
   logic [3:0] burst_q, burst_inc, wt_sel;
   logic       burst_end;

   // A burst continues only while the grant lands on the region rr_ptr is parked on.
   always_comb begin
      wt_sel = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (grant == ID_BITS'(i)) wt_sel = weight[i*4 +: 4];
      end
      burst_inc = ((grant == rr_ptr_q) ? burst_q : 4'd0) + 4'd1;
      burst_end = burst_inc >= ((wt_sel == 4'd0) ? 4'd1 : wt_sel);
      nxt_ptr   = burst_end ? grant_succ : grant;
   end
`else
   assign nxt_ptr = grant_succ;
`endif

   assign req_hs     = m_req_valid && m_req_ready;
   assign mux_hs     = m_mux_valid && m_mux_ready;
   assign issue_done = (!m_req_valid || m_req_ready) && (!m_mux_valid || m_mux_ready);

   always_ff @(posedge aclk) begin
      if (areset) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      s_req_ready = '0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               accept             = 1'b1;
               s_req_ready[grant] = 1'b1;
               state_nxt          = ISSUE;
            end
         end
         ISSUE: begin
            if (issue_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         entry_q     <= '0;
         m_req_valid <= 1'b0;
         m_mux_valid <= 1'b0;
         rr_ptr_q    <= '0;
         nxt_ptr_q   <= '0;
         credit_err  <= 1'b0;
`ifdef DMA_SCHED_WEIGHT_EN
         burst_q     <= '0;
`endif
         for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= '0;
      end else begin
         if (accept) begin
            entry_q     <= entry_sel;
            m_req_valid <= 1'b1;
            m_mux_valid <= 1'b1;
            nxt_ptr_q   <= nxt_ptr;
`ifdef DMA_SCHED_WEIGHT_EN
            burst_q     <= burst_end ? 4'd0 : burst_inc;
`endif
         end else begin
            if (req_hs) m_req_valid <= 1'b0;
            if (mux_hs) m_mux_valid <= 1'b0;
         end
         if (state_q == ISSUE && issue_done) rr_ptr_q <= nxt_ptr_q;
         // s_req_ready is the one-hot accept, so it doubles as the credit take.
         for (int i = 0; i < N_REGIONS; i++) begin
            if (s_req_ready[i] && !xfer_done[i]) begin
               cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
            end else if (!s_req_ready[i] && xfer_done[i]) begin
               if (cnt_q[i] == '0) credit_err <= 1'b1;
               else                cnt_q[i]   <= cnt_q[i] - CNT_BITS'(1);
            end
         end
      end
   end

   always_comb begin
      out_cnt = '0;
      for (int i = 0; i < N_REGIONS; i++) out_cnt[i*CNT_BITS +: CNT_BITS] = cnt_q[i];
   end

   assign m_req_data = entry_q.data;
   assign m_req_len  = entry_q.len;
   assign m_req_id   = entry_q.id;
   assign m_mux_id   = entry_q.id;
   assign m_mux_len  = entry_q.len;

endmodule

// File: tb/tb_dma_region_sched.sv
// Bench for dma_region_sched: directed scenarios plus a random run against a transaction-level model.
// Inputs change 1 unit after the rising edge; outputs are sampled on the falling edge.
module tb_dma_region_sched;
   localparam int N        = 4;
   localparam int LEN_BITS = 28;
   localparam int REQ_BITS = 96;
   localparam int MAX_OUT  = 8;
   localparam int ID_BITS  = 2;
   localparam int CNT_BITS = 4;

   logic                   aclk = 1'b0;
   logic                   areset;
   logic [N-1:0]           s_req_valid, s_req_ready, xfer_done;
   logic [N*REQ_BITS-1:0]  s_req_data;
   logic [N*LEN_BITS-1:0]  s_req_len;
   logic                   m_req_valid, m_req_ready, m_mux_valid, m_mux_ready, credit_err;
   logic [REQ_BITS-1:0]    m_req_data;
   logic [LEN_BITS-1:0]    m_req_len, m_mux_len;
   logic [ID_BITS-1:0]     m_req_id, m_mux_id;
   logic [N*CNT_BITS-1:0]  out_cnt;
   logic [REQ_BITS-1:0]    rd [N];
   logic [LEN_BITS-1:0]    rl [N];
`ifdef DMA_SCHED_WEIGHT_EN
   logic [3:0]             wt [N];
   logic [N*4-1:0]         weight;
   int                     mdl_run_g, mdl_run_n, mdl_w;
   always_comb begin
      weight = '0;
      for (int i = 0; i < N; i++) weight[i*4 +: 4] = wt[i];
   end
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state: credits, pointer, and the grant in flight.
   int                  mdl_cnt [N];
   int                  mdl_rr, mdl_id;
   bit                  mdl_err, mdl_busy, mdl_rp, mdl_mp;
   logic [LEN_BITS-1:0] mdl_len;
   logic [REQ_BITS-1:0] mdl_data;

   always_comb begin
      s_req_data = '0;
      s_req_len  = '0;
      for (int i = 0; i < N; i++) begin
         s_req_data[i*REQ_BITS +: REQ_BITS] = rd[i];
         s_req_len[i*LEN_BITS +: LEN_BITS]  = rl[i];
      end
   end

   always #5 aclk = ~aclk;

   dma_region_sched #(.N_REGIONS(N), .LEN_BITS(LEN_BITS), .REQ_BITS(REQ_BITS), .MAX_OUT(MAX_OUT)) dut (
      .aclk(aclk), .areset(areset),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_req_data(s_req_data), .s_req_len(s_req_len),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_req_data(m_req_data), .m_req_len(m_req_len), .m_req_id(m_req_id),
      .m_mux_valid(m_mux_valid), .m_mux_ready(m_mux_ready),
      .m_mux_id(m_mux_id), .m_mux_len(m_mux_len),
      .xfer_done(xfer_done), .out_cnt(out_cnt),
`ifdef DMA_SCHED_WEIGHT_EN
      .weight(weight),
`endif
      .credit_err(credit_err)
   );

   function automatic int cnt_of(int i);
      return int'(out_cnt[i*CNT_BITS +: CNT_BITS]);
   endfunction

   function automatic int id_of(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r;
      r = '0;
      if (!mdl_busy) begin
         for (int k = 0; k < N; k++) begin
            if (s_req_valid[(mdl_rr + k) % N] && mdl_cnt[(mdl_rr + k) % N] < MAX_OUT) begin
               r[(mdl_rr + k) % N] = 1'b1;
               break;
            end
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
      mdl_rr = 0; mdl_id = 0; mdl_err = 0; mdl_busy = 0; mdl_rp = 0; mdl_mp = 0;
`ifdef DMA_SCHED_WEIGHT_EN
      mdl_run_g = 0; mdl_run_n = 0; mdl_w = 1;
`endif
   endtask

   // Apply this cycle's events to the model, then step past the next rising edge.
   task automatic advance();
      logic [N-1:0] acc;
      int g;
      acc = model_ready();
      if (mdl_busy) begin
         if (mdl_rp && m_req_ready) mdl_rp = 0;
         if (mdl_mp && m_mux_ready) mdl_mp = 0;
         if (!mdl_rp && !mdl_mp) begin
            mdl_busy = 0;
`ifdef DMA_SCHED_WEIGHT_EN
            if (mdl_run_n >= mdl_w) begin mdl_rr = (mdl_id + 1) % N; mdl_run_n = 0; end
            else mdl_rr = mdl_id;
`else
            mdl_rr = (mdl_id + 1) % N;
`endif
         end
      end else if (acc != '0) begin
         g = id_of(acc);
         mdl_busy = 1; mdl_rp = 1; mdl_mp = 1;
         mdl_id = g; mdl_len = rl[g]; mdl_data = rd[g];
         mdl_cnt[g]++;
`ifdef DMA_SCHED_WEIGHT_EN
         if (mdl_run_n > 0 && mdl_run_g == g) mdl_run_n++;
         else begin mdl_run_g = g; mdl_run_n = 1; end
         mdl_w = (wt[g] == 4'd0) ? 1 : int'(wt[g]);
`endif
      end
      for (int i = 0; i < N; i++) begin
         if (xfer_done[i]) begin
            if (mdl_cnt[i] == 0) mdl_err = 1;
            else mdl_cnt[i]--;
         end
      end
      @(posedge aclk); #1;
   endtask

   task automatic do_reset();
      areset = 1'b1; s_req_valid = '0; xfer_done = '0; m_req_ready = 1'b0; m_mux_ready = 1'b0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge aclk);
      n_assert++; if (m_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", m_req_valid); end
      n_assert++; if (m_mux_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mux_valid: got %b want 0", m_mux_valid); end
      n_assert++; if (s_req_ready !== '0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_req_ready); end
      n_assert++; if (out_cnt !== '0) begin n_fail++; $display("FAIL reset_out_cnt: got %h want 0", out_cnt); end
      n_assert++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b want 0", credit_err); end
      n_assert++; if ({m_req_id, m_req_len, m_mux_id, m_mux_len} !== '0) begin n_fail++; $display("FAIL reset_id_len: got %h want 0", {m_req_id, m_req_len, m_mux_id, m_mux_len}); end
      n_assert++; if (m_req_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_req_data); end
   endtask

   task automatic test_single();
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b1;
      rd[1] = {$urandom, $urandom, $urandom}; rl[1] = 28'h40;
      s_req_valid = 4'b0010;
      @(negedge aclk);
      n_assert++; if (s_req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_accept: got %b want 0010", s_req_ready); end
      advance();
      s_req_valid = '0;
      @(negedge aclk);
      n_assert++; if (s_req_ready !== '0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", s_req_ready); end
      n_assert++; if ({m_req_valid, m_mux_valid} !== 2'b11) begin n_fail++; $display("FAIL single_valids: got %b want 11", {m_req_valid, m_mux_valid}); end
      n_assert++; if (m_req_id !== 2'd1 || m_mux_id !== 2'd1) begin n_fail++; $display("FAIL single_id: got %0d/%0d want 1/1", m_req_id, m_mux_id); end
      n_assert++; if (m_req_len !== 28'h40 || m_mux_len !== 28'h40) begin n_fail++; $display("FAIL single_len: got %h/%h want 40", m_req_len, m_mux_len); end
      n_assert++; if (m_req_data !== rd[1]) begin n_fail++; $display("FAIL single_data: got %h want %h", m_req_data, rd[1]); end
      n_assert++; if (cnt_of(1) != 1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", cnt_of(1)); end
      advance();
      @(negedge aclk);
      n_assert++; if ({m_req_valid, m_mux_valid} !== 2'b00) begin n_fail++; $display("FAIL single_drop: got %b want 00", {m_req_valid, m_mux_valid}); end
   endtask

   task automatic test_fairness();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      int ng = 0;
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b1; s_req_valid = '1;
      for (int c = 0; c < 12; c++) begin
         @(negedge aclk);
         if (s_req_ready != '0) begin
            if (ng < 6) begin
               n_assert++; if (id_of(s_req_ready) != order[ng]) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", ng, id_of(s_req_ready), order[ng]); end
            end
            ng++;
         end
         advance();
      end
      n_assert++; if (ng != 6) begin n_fail++; $display("FAIL fair_count: got %0d grants want 6", ng); end
      n_assert++; if (cnt_of(0) != 2 || cnt_of(1) != 2 || cnt_of(2) != 1 || cnt_of(3) != 1) begin n_fail++; $display("FAIL fair_cnt: got %h want 1122", out_cnt); end
      s_req_valid = '0;
   endtask

   task automatic test_credit_cap();
      int ng = 0;
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b1; s_req_valid = 4'b0001;
      for (int c = 0; c < 24; c++) begin
         @(negedge aclk);
         if (s_req_ready[0]) ng++;
         advance();
      end
      n_assert++; if (ng != MAX_OUT) begin n_fail++; $display("FAIL cap_grants: got %0d want %0d", ng, MAX_OUT); end
      @(negedge aclk);
      n_assert++; if (s_req_ready !== '0) begin n_fail++; $display("FAIL cap_stall: got %b want 0", s_req_ready); end
      n_assert++; if (cnt_of(0) != MAX_OUT) begin n_fail++; $display("FAIL cap_cnt: got %0d want %0d", cnt_of(0), MAX_OUT); end
      xfer_done = 4'b0001;
      advance();
      xfer_done = '0;
      ng = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge aclk);
         if (s_req_ready[0]) ng++;
         advance();
      end
      n_assert++; if (ng != 1) begin n_fail++; $display("FAIL cap_regrant: got %0d want 1", ng); end
      s_req_valid = 4'b0011;
      @(negedge aclk);
      n_assert++; if (s_req_ready !== 4'b0010) begin n_fail++; $display("FAIL cap_skip: got %b want 0010", s_req_ready); end
      advance();
      s_req_valid = '0;
   endtask

   task automatic test_split();
      logic [N-1:0] exp_acc;
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b0; s_req_valid = 4'b0100;
      @(negedge aclk);
      n_assert++; if (s_req_ready !== 4'b0100) begin n_fail++; $display("FAIL split_accept: got %b want 0100", s_req_ready); end
      advance();
      for (int c = 1; c <= 7; c++) begin
         if (c == 5) m_mux_ready = 1'b1;
         @(negedge aclk);
         exp_acc = (c == 6) ? 4'b0100 : 4'b0000;
         n_assert++; if (m_req_valid !== (c == 1 || c == 7)) begin n_fail++; $display("FAIL split_req_valid t+%0d: got %b want %b", c, m_req_valid, (c == 1 || c == 7)); end
         n_assert++; if (m_mux_valid !== (c <= 5 || c == 7)) begin n_fail++; $display("FAIL split_mux_valid t+%0d: got %b want %b", c, m_mux_valid, (c <= 5 || c == 7)); end
         n_assert++; if (s_req_ready !== exp_acc) begin n_fail++; $display("FAIL split_accept t+%0d: got %b want %b", c, s_req_ready, exp_acc); end
         advance();
      end
      s_req_valid = '0;
   endtask

   task automatic test_simul_and_err();
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b1; s_req_valid = 4'b0100;
      repeat (6) begin @(negedge aclk); advance(); end
      @(negedge aclk);
      n_assert++; if (cnt_of(2) != 3 || s_req_ready !== 4'b0100) begin n_fail++; $display("FAIL simul_pre: got cnt %0d ready %b want 3 0100", cnt_of(2), s_req_ready); end
      xfer_done = 4'b0100;
      advance();
      xfer_done = '0; s_req_valid = '0;
      @(negedge aclk);
      n_assert++; if (cnt_of(2) != 3) begin n_fail++; $display("FAIL simul_cnt: got %0d want 3", cnt_of(2)); end
      n_assert++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", credit_err); end
      xfer_done = 4'b1000;
      advance();
      xfer_done = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         n_assert++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky cyc %0d: got %b want 1", c, credit_err); end
         advance();
      end
      n_assert++; if (cnt_of(3) != 0) begin n_fail++; $display("FAIL err_cnt_floor: got %0d want 0", cnt_of(3)); end
      do_reset();
      @(negedge aclk);
      n_assert++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b want 0", credit_err); end
   endtask

   task automatic test_reset_issue();
      do_reset();
      m_req_ready = 1'b1; m_mux_ready = 1'b1; s_req_valid = '1;
      repeat (4) begin @(negedge aclk); advance(); end
      m_mux_ready = 1'b0;
      @(negedge aclk);
      n_assert++; if (s_req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_issue_grant: got %b want 0100", s_req_ready); end
      advance();
      @(negedge aclk);
      n_assert++; if (m_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_issue_busy: got %b want 1", m_req_valid); end
      areset = 1'b1;
      @(posedge aclk);
      #1 areset = 1'b0;
      model_reset();
      m_mux_ready = 1'b1;
      @(negedge aclk);
      n_assert++; if ({m_req_valid, m_mux_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_issue_valids: got %b want 00", {m_req_valid, m_mux_valid}); end
      n_assert++; if (out_cnt !== '0) begin n_fail++; $display("FAIL rst_issue_cnt: got %h want 0", out_cnt); end
      n_assert++; if (s_req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_issue_next: got %b want 0001", s_req_ready); end
      advance();
      s_req_valid = '0;
   endtask

`ifdef DMA_SCHED_WEIGHT_EN
   task automatic test_weight();
      int order [7] = '{0, 0, 1, 2, 3, 0, 0};
      int ng = 0;
      do_reset();
      wt[0] = 4'd2; wt[1] = 4'd1; wt[2] = 4'd0; wt[3] = 4'd1;
      m_req_ready = 1'b1; m_mux_ready = 1'b1; s_req_valid = '1;
      for (int c = 0; c < 14; c++) begin
         @(negedge aclk);
         if (s_req_ready != '0) begin
            if (ng < 7) begin
               n_assert++; if (id_of(s_req_ready) != order[ng]) begin n_fail++; $display("FAIL weight_order[%0d]: got %0d want %0d", ng, id_of(s_req_ready), order[ng]); end
            end
            ng++;
         end
         advance();
      end
      n_assert++; if (ng != 7) begin n_fail++; $display("FAIL weight_count: got %0d want 7", ng); end
      s_req_valid = '0;
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] acc;
      do_reset();
      for (int i = 0; i < N; i++) begin rd[i] = {$urandom, $urandom, $urandom}; rl[i] = LEN_BITS'($urandom); end
      for (int c = 0; c < 600; c++) begin
         m_req_ready = ($urandom_range(0, 3) != 0);
         m_mux_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (!s_req_valid[i]) s_req_valid[i] = ($urandom_range(0, 1) == 1);
            xfer_done[i] = (mdl_cnt[i] > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         end
`ifdef DMA_SCHED_WEIGHT_EN
         if (c % 64 == 0) for (int i = 0; i < N; i++) wt[i] = 4'($urandom_range(0, 3));
`endif
         @(negedge aclk);
         acc = model_ready();
         n_assert++; if (s_req_ready !== acc) begin n_fail++; $display("FAIL rand_accept cyc %0d: got %b want %b", c, s_req_ready, acc); end
         n_assert++; if ({m_req_valid, m_mux_valid} !== {mdl_rp, mdl_mp}) begin n_fail++; $display("FAIL rand_valids cyc %0d: got %b want %b", c, {m_req_valid, m_mux_valid}, {mdl_rp, mdl_mp}); end
         if (mdl_busy) begin
            n_assert++; if (m_req_id !== ID_BITS'(mdl_id) || m_mux_id !== ID_BITS'(mdl_id)) begin n_fail++; $display("FAIL rand_id cyc %0d: got %0d/%0d want %0d", c, m_req_id, m_mux_id, mdl_id); end
            n_assert++; if (m_req_len !== mdl_len || m_mux_len !== mdl_len) begin n_fail++; $display("FAIL rand_len cyc %0d: got %h/%h want %h", c, m_req_len, m_mux_len, mdl_len); end
            n_assert++; if (m_req_data !== mdl_data) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", c, m_req_data, mdl_data); end
         end
         for (int i = 0; i < N; i++) begin
            n_assert++; if (cnt_of(i) != mdl_cnt[i]) begin n_fail++; $display("FAIL rand_cnt[%0d] cyc %0d: got %0d want %0d", i, c, cnt_of(i), mdl_cnt[i]); end
         end
         n_assert++; if (credit_err !== mdl_err) begin n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", c, credit_err, mdl_err); end
         advance();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               s_req_valid[i] = ($urandom_range(0, 1) == 1);
               rd[i] = {$urandom, $urandom, $urandom};
               rl[i] = LEN_BITS'($urandom);
            end
         end
      end
      xfer_done = '0; s_req_valid = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         rd[i] = '0; rl[i] = '0;
`ifdef DMA_SCHED_WEIGHT_EN
         wt[i] = '0;
`endif
      end
      areset = 1'b1; s_req_valid = '0; xfer_done = '0; m_req_ready = 1'b0; m_mux_ready = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_credit_cap();
      test_split();
      test_simul_and_err();
      test_reset_issue();
`ifdef DMA_SCHED_WEIGHT_EN
      test_weight();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
